// File: rtl/elevator_call_scheduler_if.sv
// ----------------------------------------------------------------------------
// elevator_call_scheduler_if
// Bundles the button-side call strobe, the car-side feedback and the
// scheduler outputs into one interface.
//   master : the environment (button logic + car); drives calls and car state
//   slave  : the scheduler; drives target/direction/door/status outputs
// Signals:
//   call_valid, call_floor   : one floor call per cycle from hall/cab buttons
//   car_floor, car_complete  : car position and "stopped at requested floor"
//   target                   : floor request to the car
//   dir_up, dir_dn           : current sweep direction
//   door_open, busy          : dwell in progress / scheduler has work
//   pending                  : bitmap of outstanding calls
//   call_err                 : out-of-range call was dropped
// ----------------------------------------------------------------------------
interface elevator_call_scheduler_if #(
   parameter int NUM_FLOORS = 16,
   parameter int FLOOR_W    = 4
);
   logic                  call_valid;
   logic [FLOOR_W-1:0]    call_floor;
   logic [FLOOR_W-1:0]    car_floor;
   logic                  car_complete;
   logic [FLOOR_W-1:0]    target;
   logic                  dir_up;
   logic                  dir_dn;
   logic                  door_open;
   logic                  busy;
   logic [NUM_FLOORS-1:0] pending;
   logic                  call_err;

   modport master (
      output call_valid, call_floor, car_floor, car_complete,
      input  target, dir_up, dir_dn, door_open, busy, pending, call_err
   );

   modport slave (
      input  call_valid, call_floor, car_floor, car_complete,
      output target, dir_up, dir_dn, door_open, busy, pending, call_err
   );
endinterface

// File: rtl/elevator_call_scheduler.sv
// ----------------------------------------------------------------------------
// elevator_call_scheduler
// SCAN scheduler for a single elevator car. Latches floor calls into a pending
// bitmap, sweeps the car in one direction while calls remain ahead, reverses
// when only calls behind remain, and times the door dwell at each stop.
// Ports:
//   clk  : system clock, all state on posedge
//   rst  : asynchronous active-high reset
//   bus  : elevator_call_scheduler_if.slave (calls in, car feedback in,
//          target/dir/door/busy/pending/call_err out, all registered)
// ----------------------------------------------------------------------------
module elevator_call_scheduler #(
   parameter int NUM_FLOORS  = 16,
   parameter int FLOOR_W     = 4,
   parameter int DOOR_CYCLES = 20
) (
   input logic                       clk,
   input logic                       rst,
   elevator_call_scheduler_if.slave  bus
);
   localparam int SPAN  = 1 << FLOOR_W;
   localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DOOR_CYCLES - 1);

   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_UP   = 4'b0010,
      ST_DN   = 4'b0100,
      ST_DOOR = 4'b1000
   } state_t;

   state_t                state_q, state_d;
   logic [FLOOR_W-1:0]    target_q, target_d;
   logic                  dir_up_q, dir_up_d;
   logic                  dir_dn_q, dir_dn_d;
   logic                  door_q, door_d;
   logic                  busy_q, busy_d;
   logic [NUM_FLOORS-1:0] pending_q, pending_d;
   logic                  err_q, err_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic [SPAN-1:0]       pend_ext_s;
   logic [SPAN-1:0]       call_oh_s;
   logic [SPAN-1:0]       car_oh_s;
   logic                  call_ok_s;
   logic                  car_hit_s;
   logic                  above_s, below_s;
   logic [FLOOR_W-1:0]    near_up_s, near_dn_s;
   logic                  set_s, clr_s;
   logic                  hit_up_s, hit_dn_s;

   // Scan the pending map relative to the car: nearest call above and below.
   always_comb begin
      pend_ext_s                   = '0;
      pend_ext_s[NUM_FLOORS-1:0]   = pending_q;
      above_s   = 1'b0;
      below_s   = 1'b0;
      near_up_s = '0;
      near_dn_s = '0;
      hit_up_s  = 1'b0;
      hit_dn_s  = 1'b0;
      // Descending walk: the last hit above the car is the lowest one.
      for (int i = SPAN - 1; i >= 0; i--) begin
         hit_up_s  = pend_ext_s[i] && (i > int'(bus.car_floor));
         above_s   = above_s | hit_up_s;
         near_up_s = hit_up_s ? FLOOR_W'(i) : near_up_s;
      end
      // Ascending walk: the last hit below the car is the highest one.
      for (int i = 0; i < SPAN; i++) begin
         hit_dn_s  = pend_ext_s[i] && (i < int'(bus.car_floor));
         below_s   = below_s | hit_dn_s;
         near_dn_s = hit_dn_s ? FLOOR_W'(i) : near_dn_s;
      end
      car_hit_s = pend_ext_s[bus.car_floor];
      call_ok_s = bus.call_valid && (int'(bus.call_floor) < NUM_FLOORS);
      call_oh_s = {{(SPAN-1){1'b0}}, 1'b1} << bus.call_floor;
      car_oh_s  = {{(SPAN-1){1'b0}}, 1'b1} << bus.car_floor;
   end

   // Next-state, target, direction and dwell counter for the SCAN FSM.
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      dir_up_d = dir_up_q;
      dir_dn_d = dir_dn_q;
      cnt_d    = cnt_q;
      clr_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            dir_up_d = 1'b0;
            dir_dn_d = 1'b0;
            if (car_hit_s) begin
               state_d = ST_DOOR;
               clr_s   = 1'b1;
               cnt_d   = '0;
            end else if (above_s) begin
               state_d  = ST_UP;
               target_d = near_up_s;
               dir_up_d = 1'b1;
            end else if (below_s) begin
               state_d  = ST_DN;
               target_d = near_dn_s;
               dir_dn_d = 1'b1;
            end else begin
               target_d = (int'(bus.car_floor) < NUM_FLOORS) ? bus.car_floor : target_q;
            end
         end
         ST_UP: begin
            dir_up_d = 1'b1;
            dir_dn_d = 1'b0;
            if (bus.car_complete && (bus.car_floor == target_q)) begin
               state_d = ST_DOOR;
               clr_s   = 1'b1;
               cnt_d   = '0;
            end else if ((bus.car_floor != target_q) && above_s) begin
               // Re-aim every cycle so a call appearing en route is served first.
               target_d = near_up_s;
            end else begin
               target_d = target_q;
            end
         end
         ST_DN: begin
            dir_up_d = 1'b0;
            dir_dn_d = 1'b1;
            if (bus.car_complete && (bus.car_floor == target_q)) begin
               state_d = ST_DOOR;
               clr_s   = 1'b1;
               cnt_d   = '0;
            end else if ((bus.car_floor != target_q) && below_s) begin
               target_d = near_dn_s;
            end else begin
               target_d = target_q;
            end
         end
         ST_DOOR: begin
            if (call_ok_s && (bus.call_floor == bus.car_floor)) begin
               // Someone pressed for this floor while the door is open: extend.
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (dir_up_q && above_s) begin
                  state_d  = ST_UP;
                  target_d = near_up_s;
               end else if (dir_dn_q && below_s) begin
                  state_d  = ST_DN;
                  target_d = near_dn_s;
               end else if (above_s) begin
                  state_d  = ST_UP;
                  target_d = near_up_s;
                  dir_up_d = 1'b1;
                  dir_dn_d = 1'b0;
               end else if (below_s) begin
                  state_d  = ST_DN;
                  target_d = near_dn_s;
                  dir_up_d = 1'b0;
                  dir_dn_d = 1'b1;
               end else begin
                  state_d  = ST_IDLE;
                  dir_up_d = 1'b0;
                  dir_dn_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d  = ST_IDLE;
            target_d = '0;
            dir_up_d = 1'b0;
            dir_dn_d = 1'b0;
            cnt_d    = '0;
         end
      endcase
   end

   // Pending map update and registered status outputs; a clear beats a set.
   always_comb begin
      set_s     = call_ok_s && !((state_q == ST_DOOR) && (bus.call_floor == bus.car_floor));
      pending_d = (pending_q | (set_s ? call_oh_s[NUM_FLOORS-1:0] : '0))
                  & ~(clr_s ? car_oh_s[NUM_FLOORS-1:0] : '0);
      door_d    = (state_d == ST_DOOR);
      busy_d    = (state_d != ST_IDLE) || (pending_d != '0);
      err_d     = bus.call_valid && !call_ok_s;
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         target_q  <= '0;
         dir_up_q  <= 1'b0;
         dir_dn_q  <= 1'b0;
         door_q    <= 1'b0;
         busy_q    <= 1'b0;
         pending_q <= '0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         dir_up_q  <= dir_up_d;
         dir_dn_q  <= dir_dn_d;
         door_q    <= door_d;
         busy_q    <= busy_d;
         pending_q <= pending_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.target    = target_q;
   assign bus.dir_up    = dir_up_q;
   assign bus.dir_dn    = dir_dn_q;
   assign bus.door_open = door_q;
   assign bus.busy      = busy_q;
   assign bus.pending   = pending_q;
   assign bus.call_err  = err_q;
endmodule
